// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types and default sizing for the snoop bus arbiter and its interface.
package snoop_bus_arbiter_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int CMD_W_DEF   = 3;
  localparam int TIMEOUT_DEF = 16;

  typedef logic [CMD_W_DEF-1:0] snoop_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_HOLD = 3'd4
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus signal bundle between the D-cache controllers (master) and the arbiter (slave).
interface snoop_bus_arbiter_if
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ-1:0]        release_bus;
  logic [NUM_REQ-1:0]        snoop_ack;
  logic [NUM_REQ-1:0]        snoop_hit;
  logic                      bus_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      snoop_valid;
  logic [ADDR_W-1:0]         snoop_addr;
  logic [CMD_W-1:0]          snoop_cmd;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_hit;
  logic                      resp_timeout;

  modport master (
    output req, req_addr, req_cmd, release_bus, snoop_ack, snoop_hit,
    input  bus_ready, grant, snoop_valid, snoop_addr, snoop_cmd,
           resp_valid, resp_hit, resp_timeout
  );

  modport slave (
    input  req, req_addr, req_cmd, release_bus, snoop_ack, snoop_hit,
    output bus_ready, grant, snoop_valid, snoop_addr, snoop_cmd,
           resp_valid, resp_hit, resp_timeout
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module snoop_bus_arbiter_rr_picker
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan ptr+1 .. ptr+NUM_REQ so the previous owner is considered last.
  always_comb begin
    int unsigned j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus owner: round-robin grant, command broadcast, ack/hit collection with timeout,
// one-cycle response to the owner, then hold until the owner releases.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  snoop_bus_arbiter_if.slave arb
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_seen_q, ack_seen_d, hit_seen_q, hit_seen_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                snoop_valid_q, snoop_valid_d;
  logic                resp_hit_q, resp_hit_d, resp_timeout_q, resp_timeout_d;
  logic                bus_ready_q, bus_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [NUM_REQ-1:0]  pick_grant_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_valid_s;
  logic [NUM_REQ-1:0]  ack_now_s, hit_now_s;
  logic                all_acked_s, owner_rel_s;

  snoop_bus_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i   (arb.req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // The owner's own ack/hit never contributes; this cycle's acks count immediately.
  assign ack_now_s   = ack_seen_q | (arb.snoop_ack & ~grant_q);
  assign hit_now_s   = hit_seen_q | (arb.snoop_ack & arb.snoop_hit & ~grant_q);
  assign all_acked_s = &(ack_now_s | grant_q);
  assign owner_rel_s = |(arb.release_bus & grant_q);

  // Next-state and next-output logic for the arbitration sequence.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    grant_d        = grant_q;
    ack_seen_d     = ack_seen_q;
    hit_seen_d     = hit_seen_q;
    count_d        = count_q;
    addr_d         = addr_q;
    cmd_d          = cmd_q;
    snoop_valid_d  = 1'b0;
    resp_valid_d   = '0;
    resp_hit_d     = 1'b0;
    resp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d       = ST_CMD;
          grant_d       = pick_grant_s;
          owner_d       = pick_idx_s;
          addr_d        = arb.req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
          cmd_d         = arb.req_cmd[int'(pick_idx_s)*CMD_W +: CMD_W];
          snoop_valid_d = 1'b1;
          ack_seen_d    = '0;
          hit_seen_d    = '0;
          count_d       = '0;
        end else begin
          grant_d = '0;
        end
      end
      ST_CMD, ST_WAIT: begin
        ack_seen_d = ack_now_s;
        hit_seen_d = hit_now_s;
        if (all_acked_s) begin
          state_d      = ST_RESP;
          resp_valid_d = grant_q;
          resp_hit_d   = |hit_now_s;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          state_d        = ST_RESP;
          resp_valid_d   = grant_q;
          resp_hit_d     = |hit_now_s;
          resp_timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_RESP, ST_HOLD: begin
        if (owner_rel_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    bus_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= IDX_W'(NUM_REQ - 1);
      owner_q        <= '0;
      grant_q        <= '0;
      ack_seen_q     <= '0;
      hit_seen_q     <= '0;
      count_q        <= '0;
      addr_q         <= '0;
      cmd_q          <= '0;
      snoop_valid_q  <= 1'b0;
      resp_valid_q   <= '0;
      resp_hit_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      bus_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      grant_q        <= grant_d;
      ack_seen_q     <= ack_seen_d;
      hit_seen_q     <= hit_seen_d;
      count_q        <= count_d;
      addr_q         <= addr_d;
      cmd_q          <= cmd_d;
      snoop_valid_q  <= snoop_valid_d;
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      resp_timeout_q <= resp_timeout_d;
      bus_ready_q    <= bus_ready_d;
    end
  end

  assign arb.bus_ready    = bus_ready_q;
  assign arb.grant        = grant_q;
  assign arb.snoop_valid  = snoop_valid_q;
  assign arb.snoop_addr   = addr_q;
  assign arb.snoop_cmd    = cmd_q;
  assign arb.resp_valid   = resp_valid_q;
  assign arb.resp_hit     = resp_hit_q;
  assign arb.resp_timeout = resp_timeout_q;

endmodule
